// File: rtl/ucode_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ucode_sequencer_if : decode request, microcode ROM and micro-op issue signals
// Revision 1.0
// ---------------------------------------------------------------------------
interface ucode_sequencer_if #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int MAX_UOPS = 16
);
  localparam int CNT_W = $clog2(MAX_UOPS + 1);

  logic              mi_valid;
  logic              mi_ready;
  logic [ADDR_W-1:0] mi_entry;
  logic [DATA_W-1:0] mi_ir1;
  logic [DATA_W-1:0] mi_ir2;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_ir1;
  logic [DATA_W-1:0] rom_ir2;
  logic [DATA_W-1:0] rom_data;

  logic              uop_valid;
  logic              uop_ready;
  logic [DATA_W-1:0] uop_w0;
  logic [DATA_W-1:0] uop_w1;

  logic              busy;
  logic              seq_done;
  logic              seq_err;
  logic [CNT_W-1:0]  uop_count;

  // Sequencer side.
  modport slave (
    input  mi_valid, mi_entry, mi_ir1, mi_ir2, rom_data, uop_ready,
    output mi_ready, rom_addr, rom_ir1, rom_ir2, uop_valid, uop_w0, uop_w1,
           busy, seq_done, seq_err, uop_count
  );

  // Decode / ROM / issue-stage side.
  modport master (
    output mi_valid, mi_entry, mi_ir1, mi_ir2, rom_data, uop_ready,
    input  mi_ready, rom_addr, rom_ir1, rom_ir2, uop_valid, uop_w0, uop_w1,
           busy, seq_done, seq_err, uop_count
  );
endinterface
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ucode_sequencer : expands one macro-instruction into micro-ops from the ROM
// Revision 1.0
// ---------------------------------------------------------------------------
module ucode_sequencer #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int MAX_UOPS = 16
) (
  input wire               clk,
  input wire               rst,
  ucode_sequencer_if.slave bus
);
  localparam int                CNT_W   = $clog2(MAX_UOPS + 1);
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_UOPS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_ISSUE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              wrapped;
  logic [DATA_W-1:0] ir1_q;
  logic [DATA_W-1:0] ir2_q;
  logic [DATA_W-1:0] w0_q;
  logic [DATA_W-1:0] w1_q;
  logic [CNT_W-1:0]  count_q;
  logic              uop_valid_q;
  logic              mi_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [ADDR_W:0]   pc_step;
  logic [CNT_W-1:0]  count_inc;

  // Carry out of pc+2 marks a pair that ran past the top of the ROM.
  assign pc_step   = {1'b0, pc} + (ADDR_W + 1)'(2);
  assign count_inc = count_q + CNT_W'(1);

  assign bus.rom_addr  = (state == S_FETCH1) ? pc + ADDR_W'(1) : pc;
  assign bus.rom_ir1   = ir1_q;
  assign bus.rom_ir2   = ir2_q;
  assign bus.uop_w0    = w0_q;
  assign bus.uop_w1    = w1_q;
  assign bus.uop_valid = uop_valid_q;
  assign bus.mi_ready  = mi_ready_q;
  assign bus.busy      = busy_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_err   = err_q;
  assign bus.uop_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      wrapped     <= 1'b0;
      ir1_q       <= '0;
      ir2_q       <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      count_q     <= '0;
      uop_valid_q <= 1'b0;
      mi_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mi_valid && mi_ready_q) begin
            pc         <= bus.mi_entry;
            ir1_q      <= bus.mi_ir1;
            ir2_q      <= bus.mi_ir2;
            count_q    <= '0;
            wrapped    <= 1'b0;
            mi_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= S_FETCH0;
          end
        end
        S_FETCH0: begin
          // A pair starting at the last word, or after pc wrapped, is out of the ROM.
          if (pc == PC_LAST || wrapped) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            w0_q  <= bus.rom_data;
            state <= S_FETCH1;
          end
        end
        S_FETCH1: begin
          w1_q <= bus.rom_data;
          if (w0_q == '0 && bus.rom_data == '0) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            uop_valid_q <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.uop_ready) begin
            uop_valid_q <= 1'b0;
            count_q     <= count_inc;
            pc          <= pc_step[ADDR_W-1:0];
            wrapped     <= pc_step[ADDR_W];
            if (count_inc == CNT_MAX) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end else begin
              state <= S_FETCH0;
            end
          end
        end
        S_DONE, S_ERR: begin
          mi_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          uop_valid_q <= 1'b0;
          mi_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ucode_sequencer : directed self-checking bench for ucode_sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ucode_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rom [0:127];

  // Shared stimulus; sel chooses which instance receives the request.
  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic [6:0]  req_entry = '0;
  logic [15:0] req_ir1   = '0;
  logic [15:0] req_ir2   = '0;
  logic        rdy       = 1'b0;

  ucode_sequencer_if #(.ADDR_W(7), .DATA_W(16), .MAX_UOPS(16)) b16 ();
  ucode_sequencer_if #(.ADDR_W(7), .DATA_W(16), .MAX_UOPS(4))  b4  ();

  ucode_sequencer #(.ADDR_W(7), .DATA_W(16), .MAX_UOPS(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );
  ucode_sequencer #(.ADDR_W(7), .DATA_W(16), .MAX_UOPS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  assign b16.mi_valid  = req_valid & ~sel;
  assign b16.mi_entry  = req_entry;
  assign b16.mi_ir1    = req_ir1;
  assign b16.mi_ir2    = req_ir2;
  assign b16.uop_ready = rdy;
  assign b16.rom_data  = rom[b16.rom_addr];

  assign b4.mi_valid   = req_valid & sel;
  assign b4.mi_entry   = req_entry;
  assign b4.mi_ir1     = req_ir1;
  assign b4.mi_ir2     = req_ir2;
  assign b4.uop_ready  = rdy;
  assign b4.rom_data   = rom[b4.rom_addr];

  logic        s_mi_ready, s_uop_valid, s_busy, s_seq_done, s_seq_err;
  logic [15:0] s_uop_w0, s_uop_w1, s_rom_ir1, s_rom_ir2;
  logic [4:0]  s_uop_count;

  always_comb begin
    s_mi_ready  = sel ? b4.mi_ready  : b16.mi_ready;
    s_uop_valid = sel ? b4.uop_valid : b16.uop_valid;
    s_busy      = sel ? b4.busy      : b16.busy;
    s_seq_done  = sel ? b4.seq_done  : b16.seq_done;
    s_seq_err   = sel ? b4.seq_err   : b16.seq_err;
    s_uop_w0    = sel ? b4.uop_w0    : b16.uop_w0;
    s_uop_w1    = sel ? b4.uop_w1    : b16.uop_w1;
    s_rom_ir1   = sel ? b4.rom_ir1   : b16.rom_ir1;
    s_rom_ir2   = sel ? b4.rom_ir2   : b16.rom_ir2;
    s_uop_count = sel ? {2'b00, b4.uop_count} : b16.uop_count;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] first_w0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one macro and follow it to its done/err pulse, checking every micro-op.
  task automatic run_seq(input bit use4, input logic [6:0] entry, input logic [15:0] ir1,
                         input logic [15:0] ir2, input int stall, input int exp_uops,
                         input bit exp_done, input int exp_err_cyc);
    int          cyc, n, scnt, last_hs, done_n, err_n, err_cyc;
    bit          fin;
    logic [15:0] h0, h1;
    logic [6:0]  a, a1;
    n = 0; scnt = 0; last_hs = 0; done_n = 0; err_n = 0; err_cyc = -1; fin = 0;
    h0 = '0; h1 = '0;
    sel = use4;
    @(negedge clk);
    check("mi_ready_idle", s_mi_ready, 1);
    req_valid = 1'b1; req_entry = entry; req_ir1 = ir1; req_ir2 = ir2;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    req_valid = 1'b0;
    check("rom_ir1", s_rom_ir1, ir1);
    check("rom_ir2", s_rom_ir2, ir2);
    check("busy", s_busy, 1);
    while (!fin && cyc < 400) begin
      rdy = 1'b0;
      if (s_seq_done) begin
        done_n++;
        check("done_lat", cyc, last_hs + 3);
        fin = 1;
      end
      if (s_seq_err) begin
        err_n++;
        err_cyc = cyc;
        fin = 1;
      end
      if (s_uop_valid) begin
        if (scnt == 0) begin
          h0 = s_uop_w0;
          h1 = s_uop_w1;
          if (n == 0) begin
            check("first_lat", cyc, 3);
            first_w0 = s_uop_w0;
          end
        end else begin
          check("w0_hold", s_uop_w0, h0);
          check("w1_hold", s_uop_w1, h1);
        end
        if (scnt < stall) begin
          scnt++;
        end else begin
          rdy = 1'b1;
          a  = entry + 7'(2 * n);
          a1 = a + 7'd1;
          check("uop_w0", s_uop_w0, rom[a]);
          check("uop_w1", s_uop_w1, rom[a1]);
          if (stall == 0) check("hs_cyc", cyc, 3 + 3 * n);
          last_hs = cyc;
          n++;
          scnt = 0;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    rdy = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("uops", n, exp_uops);
    check("uop_count", s_uop_count, exp_uops);
    check("done_pulses", done_n, exp_done);
    check("err_pulses", err_n, !exp_done);
    if (exp_err_cyc >= 0) check("err_cyc", err_cyc, exp_err_cyc);
    @(negedge clk);
    check("pulse_1cyc", s_seq_done | s_seq_err, 0);
    check("ready_back", s_mi_ready, 1);
    check("busy_idle", s_busy, 0);
    check("count_held", s_uop_count, exp_uops);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0]   = 16'h1111; rom[1]   = 16'h2222;
    rom[11]  = 16'hE105; rom[12]  = 16'h1234;
    rom[13]  = 16'h0000; rom[14]  = 16'h00AB;
    rom[15]  = 16'h4C21; rom[16]  = 16'h0000;
    rom[17]  = 16'h7F01; rom[18]  = 16'h8002;
    rom[21]  = 16'h5A5A;
    for (int i = 22; i < 34; i++) rom[i] = 16'h3000 + 16'(i);
    rom[126] = 16'hC0DE; rom[127] = 16'hBEEF;
    first_w0 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mi_ready", s_mi_ready, 1);
    check("rst_busy", s_busy, 0);
    check("rst_uop_valid", s_uop_valid, 0);
    check("rst_uop_count", s_uop_count, 0);
    check("rst_done_err", {s_seq_done, s_seq_err}, 0);
    check("rst_rom_ir1", s_rom_ir1, 0);
    check("rst_uop_w0", s_uop_w0, 0);

    run_seq(0, 7'd11, 16'h0290, 16'h1F2E, 0, 4, 1, -1);
    check("w0_op", first_w0[15:10], 6'b111000);
    check("w0_reg", first_w0[9:7], 3'b010);
    run_seq(0, 7'd20, 16'h0450, 16'h0001, 0, 7, 1, -1);
    run_seq(0, 7'd11, 16'h0290, 16'h1F2E, 5, 4, 1, -1);
    run_seq(1, 7'd20, 16'h0450, 16'h0001, 0, 4, 0, 13);
    run_seq(0, 7'd127, 16'h0000, 16'h0000, 0, 0, 0, 2);
    run_seq(0, 7'd126, 16'h0000, 16'h0000, 0, 1, 0, 5);

    // Reset while a micro-op is waiting in ISSUE.
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_entry = 7'd20; req_ir1 = 16'h0450; req_ir2 = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (s_uop_valid) seen = 1;
      else @(negedge clk);
    end
    check("rst_reach_issue", seen, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_uop_valid", s_uop_valid, 0);
    check("midrst_busy", s_busy, 0);
    check("midrst_mi_ready", s_mi_ready, 1);
    check("midrst_count", s_uop_count, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (s_seq_done || s_seq_err) seen = 1;
      @(negedge clk);
    end
    check("midrst_no_pulse", seen, 0);
    run_seq(0, 7'd11, 16'h0290, 16'h1F2E, 0, 4, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
